// File: rtl/jac_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jac_pkg
//  Description : Definitions shared by the program-memory loader and the
//                program memory: default address/instruction widths, the
//                bytes-per-instruction ratio and the loader state encoding.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package jac_pkg;

    localparam int BYTES_PER_WORD     = 2;
    localparam int PC_WIDTH_DEFAULT   = 8;
    localparam int DATA_WIDTH_DEFAULT = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : Program-memory writer. Receives LEN, 2*LEN data bytes
//                (high byte first per word) and an XOR checksum over a
//                valid/ready byte link, and writes each assembled 16-bit
//                word to consecutive program-memory addresses from 0.
//  Ports       : clk, res        - clock, synchronous active-high reset
//                start           - begins a load (ignored while busy)
//                byte_valid/data - incoming byte stream
//                byte_ready      - byte accepted this cycle when valid
//                we/waddr/wdata  - program-memory write port
//                busy            - load in progress
//                done            - one-cycle pulse on a good load
//                err             - sticky error (bad LEN or checksum)
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import jac_pkg::*;
#(
    parameter int PC_WIDTH  = PC_WIDTH_DEFAULT,
    parameter int DataWidth = DATA_WIDTH_DEFAULT,
    parameter int CMD_CNT   = 64
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    output logic                 byte_ready,
    output logic                 we,
    output logic [PC_WIDTH-1:0]  waddr,
    output logic [DataWidth-1:0] wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam logic [8:0] c_CMD_MAX = 9'(CMD_CNT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [7:0]            r_len;
    logic [PC_WIDTH:0]     r_cnt;     // one extra bit so CMD_CNT = 2^PC_WIDTH fits
    logic [PC_WIDTH:0]     w_cnt_inc;
    logic [7:0]            r_chk;
    logic [7:0]            r_hi;
    logic                  r_we;
    logic [PC_WIDTH-1:0]   r_waddr;
    logic [DataWidth-1:0]  r_wdata;
    logic                  r_done;
    logic                  r_err;
    logic                  w_active;
    logic                  w_xfer;
    logic                  w_len_ok;
    logic                  w_more;

    assign w_active  = (r_state != ST_IDLE);
    assign w_xfer    = byte_valid && w_active;
    assign w_len_ok  = (byte_data != 8'd0) && ({1'b0, byte_data} <= c_CMD_MAX);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_more    = (32'(w_cnt_inc) < 32'(r_len));

    always_comb begin
        w_state_nxt = r_state;
        byte_ready  = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LEN;
            end
            ST_LEN: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) w_state_nxt = w_len_ok ? ST_HI : ST_IDLE;
            end
            ST_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) w_state_nxt = ST_LO;
            end
            ST_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) w_state_nxt = w_more ? ST_HI : ST_CHK;
            end
            ST_CHK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (w_xfer) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_state <= ST_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_chk   <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_we    <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err <= 1'b0;
                        r_cnt <= '0;
                        r_chk <= '0;
                    end
                end
                ST_LEN: begin
                    if (w_xfer) begin
                        if (w_len_ok) r_len <= byte_data;
                        else          r_err <= 1'b1;
                    end
                end
                ST_HI: begin
                    if (w_xfer) begin
                        r_hi  <= byte_data;
                        r_chk <= r_chk ^ byte_data;
                    end
                end
                ST_LO: begin
                    // Write is registered: we/waddr/wdata appear the cycle
                    // after the low byte, overlapping the next HI byte.
                    if (w_xfer) begin
                        r_chk   <= r_chk ^ byte_data;
                        r_we    <= 1'b1;
                        r_waddr <= r_cnt[PC_WIDTH-1:0];
                        r_wdata <= DataWidth'({r_hi, byte_data});
                        r_cnt   <= w_cnt_inc;
                    end
                end
                ST_CHK: begin
                    if (w_xfer) begin
                        if (byte_data == r_chk) r_done <= 1'b1;
                        else                    r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign we    = r_we;
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign done  = r_done;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. A stream-level model
//                (byte position arithmetic over LEN/data/CHK) predicts every
//                output each cycle; load-level and literal checks pin it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready;
    logic        we;
    logic [7:0]  waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(
        .PC_WIDTH  (8),
        .DataWidth (16),
        .CMD_CNT   (64)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy, m_err, m_we, m_done;
    logic [7:0] m_addr;
    logic [15:0] m_data;
    logic [7:0] m_hi, m_xor;
    int         m_pos, m_len;
    bit         chk_en = 0;

    task automatic model_reset();
        m_busy = 0; m_err = 0; m_we = 0; m_done = 0;
        m_addr = 8'd0; m_data = 16'd0; m_hi = 8'd0; m_xor = 8'd0;
        m_pos = 0; m_len = 0;
    endtask

    // Position 0 is LEN, 1..2*LEN are data (odd = hi), then CHK.
    task automatic model_accept(input logic [7:0] b);
        if (m_pos == 0) begin
            if (b >= 8'd1 && b <= 8'd64) begin
                m_len = int'(b);
                m_pos = 1;
            end else begin
                m_err  = 1;
                m_busy = 0;
            end
        end else if (m_pos <= 2 * m_len) begin
            m_xor = m_xor ^ b;
            if (m_pos % 2 == 1) m_hi = b;
            else begin
                m_we   = 1;
                m_addr = 8'((m_pos / 2) - 1);
                m_data = {m_hi, b};
            end
            m_pos++;
        end else begin
            if (b == m_xor) m_done = 1;
            else            m_err  = 1;
            m_busy = 0;
            m_pos  = 0;
        end
    endtask

    // ---------------- per-cycle compare + write log ----------------
    logic [7:0]  log_addr [0:8191];
    logic [15:0] log_data [0:8191];
    int          wr_count   = 0;
    int          done_count = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       busy,       m_busy);
            check("byte_ready", byte_ready, m_busy);
            check("we",         we,         m_we);
            check("waddr",      waddr,      m_addr);
            check("wdata",      wdata,      m_data);
            check("done",       done,       m_done);
            check("err",        err,        m_err);
            if (we === 1'b1) begin
                if (wr_count < 8192) begin
                    log_addr[wr_count] = waddr;
                    log_data[wr_count] = wdata;
                end
                wr_count++;
            end
            if (done === 1'b1) done_count++;
            m_we   = 0;
            m_done = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        res = 1'b1; start = 1'b0; byte_valid = 1'b0;
        @(posedge clk);
        model_reset();
        chk_en = 1;
        @(negedge clk);
        res = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 1'b0; byte_valid = 1'b0;
            @(posedge clk);
        end
    endtask

    task automatic pulse_start();
        bit was_busy;
        @(negedge clk);
        start = 1'b1; byte_valid = 1'b0;
        was_busy = m_busy;
        @(posedge clk);
        if (!was_busy) begin
            m_busy = 1; m_err = 0; m_pos = 0; m_xor = 8'd0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int  waited = 0;
        bit  ok     = 0;
        while (!ok) begin
            @(negedge clk);
            start = 1'b0; byte_valid = 1'b1; byte_data = b;
            if (byte_ready === 1'b1) begin
                @(posedge clk);
                model_accept(b);
                ok = 1;
            end else begin
                @(posedge clk);
                waited++;
                if (waited > 8) begin
                    n_checks++; n_fail++;
                    $display("FAIL byte_timeout: byte_ready stayed 0, required 1 (t=%0t)", $time);
                    ok = 1;
                end
            end
        end
    endtask

    task automatic send_stream(input logic [7:0] q[$], input int gap, input bit rand_gap);
        for (int i = 0; i < q.size(); i++) begin
            int g;
            if (i > 0 && !m_busy) break;
            g = rand_gap ? int'($urandom_range(0, gap)) : gap;
            for (int k = 0; k < g; k++) begin
                if (rand_gap && $urandom_range(0, 15) == 0) pulse_start();
                else idle(1);
            end
            send_byte(q[i]);
        end
    endtask

    // Read DUT at a quiet negedge with inputs released.
    task automatic quiet();
        @(negedge clk);
        start = 1'b0; byte_valid = 1'b0;
        #1;
    endtask

    logic [7:0] nominal [$] = '{8'h03, 8'h49, 8'h03, 8'h4A, 8'h14, 8'h4B, 8'hF0, 8'hAF};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q [$];
        int bw, bd;

        repeat (2) @(posedge clk);
        do_reset();
        #1;
        check("rst_busy", busy, 0);  check("rst_ready", byte_ready, 0);
        check("rst_we", we, 0);      check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0); check("rst_done", done, 0);
        check("rst_err", err, 0);

        // Nominal load
        bw = wr_count; bd = done_count;
        pulse_start();
        send_stream(nominal, 0, 0);
        idle(3); quiet();
        check("nom_nwr", wr_count - bw, 3);
        check("nom_a0", log_addr[bw],   8'h00); check("nom_d0", log_data[bw],   16'h4903);
        check("nom_a1", log_addr[bw+1], 8'h01); check("nom_d1", log_data[bw+1], 16'h4A14);
        check("nom_a2", log_addr[bw+2], 8'h02); check("nom_d2", log_data[bw+2], 16'h4BF0);
        check("nom_done", done_count - bd, 1);
        check("nom_err", err, 0);

        // Bad LEN 00 and 41
        for (int v = 0; v < 2; v++) begin
            q = {(v == 0) ? 8'h00 : 8'h41, 8'h49, 8'h03};
            bw = wr_count;
            pulse_start();
            send_stream(q, 0, 0);
            quiet();
            check("badlen_busy", busy, 0);
            check("badlen_err", err, 1);
            idle(2); quiet();
            check("badlen_nwr", wr_count - bw, 0);
        end
        bd = done_count;
        pulse_start();
        send_stream(nominal, 0, 0);
        idle(2); quiet();
        check("recover_err", err, 0);
        check("recover_done", done_count - bd, 1);

        // Checksum mismatch
        q = nominal; q[7] = 8'h00;
        bw = wr_count; bd = done_count;
        pulse_start();
        send_stream(q, 0, 0);
        idle(3); quiet();
        check("badchk_nwr", wr_count - bw, 3);
        check("badchk_err", err, 1);
        check("badchk_done", done_count - bd, 0);

        // Backpressure gaps of 3
        bw = wr_count; bd = done_count;
        pulse_start();
        send_stream(nominal, 3, 0);
        idle(3); quiet();
        check("gap_nwr", wr_count - bw, 3);
        check("gap_d2", log_data[bw+2], 16'h4BF0);
        check("gap_done", done_count - bd, 1);

        // Full size: word i = {i, ~i}; XOR of all bytes is 0
        q = {8'h40};
        for (int i = 0; i < 64; i++) begin
            q.push_back(8'(i));
            q.push_back(~8'(i));
        end
        q.push_back(8'h00);
        bw = wr_count; bd = done_count;
        pulse_start();
        send_stream(q, 0, 0);
        idle(3); quiet();
        check("full_nwr", wr_count - bw, 64);
        check("full_alast", log_addr[bw+63], 8'h3F);
        check("full_dlast", log_data[bw+63], 16'h3FC0);
        check("full_done", done_count - bd, 1);

        // Reset after the second word's HI byte
        q = {8'h03, 8'h49, 8'h03, 8'h4A};
        bw = wr_count;
        pulse_start();
        send_stream(q, 0, 0);
        do_reset();
        #1;
        check("rmid_busy", busy, 0); check("rmid_we", we, 0);
        check("rmid_waddr", waddr, 0); check("rmid_wdata", wdata, 0);
        check("rmid_err", err, 0);
        idle(2); quiet();
        check("rmid_nwr", wr_count - bw, 1);
        check("rmid_a0", log_addr[bw], 8'h00);

        // Start pulsed mid-load after a bad checksum left err set
        q = nominal; q[7] = 8'h00;
        pulse_start(); send_stream(q, 0, 0); idle(1);
        bw = wr_count; bd = done_count;
        pulse_start();
        send_stream('{8'h03, 8'h49, 8'h03}, 0, 0);
        pulse_start();
        send_stream('{8'h4A, 8'h14, 8'h4B, 8'hF0, 8'hAF}, 0, 0);
        idle(3); quiet();
        check("smid_nwr", wr_count - bw, 3);
        check("smid_done", done_count - bd, 1);

        // Randomized loads
        for (int t = 0; t < 40; t++) begin
            logic [7:0] lb, hi, lo, x;
            int  nw;
            bit  good, valid;
            if ($urandom_range(0, 7) == 0)
                lb = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(65, 255));
            else
                lb = 8'($urandom_range(1, 64));
            valid = (lb >= 8'd1 && lb <= 8'd64);
            nw    = valid ? int'(lb) : 1;
            good  = ($urandom_range(0, 4) != 0);
            x = 8'd0;
            q = {lb};
            for (int w = 0; w < nw; w++) begin
                hi = 8'($urandom); lo = 8'($urandom);
                x  = x ^ hi ^ lo;
                q.push_back(hi); q.push_back(lo);
            end
            q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
            bw = wr_count; bd = done_count;
            idle($urandom_range(0, 2));
            pulse_start();
            send_stream(q, 2, 1);
            idle(2); quiet();
            check("rnd_nwr", wr_count - bw, valid ? nw : 0);
            check("rnd_done", done_count - bd, (valid && good) ? 1 : 0);
            check("rnd_err", err, (valid && good) ? 0 : 1);
        end

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
